// File: rtl/sub_fp_clk.sv
// Multi-cycle IEEE-754 single-precision subtractor: data_out = data_in_1 - data_in_2.
// Define SUB_FP_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module sub_fp_clk #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_sub_fp_clk,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid
);

  localparam int EXT_W = MAN_WIDTH + 4;
  localparam int SUM_W = EXT_W + 1;
  localparam int EXS_W = EXP_WIDTH + 2;
  localparam int LZ_W  = $clog2(EXT_W + 1);
  localparam logic [EXP_WIDTH-1:0]  EXP_ALL1 = '1;
  localparam logic [DATA_WIDTH-1:0] QNAN     = {1'b0, EXP_ALL1, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SUB, S_NORM, S_ROUND} state_t;

  function automatic logic [LZ_W-1:0] lzc(input logic [EXT_W-1:0] v);
    lzc = LZ_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++)
      if (v[i]) lzc = LZ_W'(EXT_W - 1 - i);
  endfunction

  // Returns {carry, 24-bit significand}; a carry means the significand wrapped to 2.0.
  function automatic logic [MAN_WIDTH+1:0] round_mant(input logic [EXT_W-1:0] m);
    logic inc;
`ifdef SUB_FP_RNE_EN
    inc = m[2] & (m[1] | m[0] | m[3]);
`else
    inc = 1'b0;
`endif
    round_mant = {1'b0, m[EXT_W-1:3]} + (MAN_WIDTH+2)'(inc);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack_sat(input logic                    sign,
                                                     input logic signed [EXS_W-1:0] exp,
                                                     input logic [MAN_WIDTH+1:0]    mant);
    logic signed [EXS_W-1:0] e;
    logic [MAN_WIDTH-1:0]    frac;
    e    = mant[MAN_WIDTH+1] ? exp + $signed(EXS_W'(1)) : exp;
    frac = mant[MAN_WIDTH+1] ? mant[MAN_WIDTH:1] : mant[MAN_WIDTH-1:0];
    if (e >= $signed(EXS_W'(EXP_ALL1)))
      pack_sat = {sign, EXP_ALL1, {MAN_WIDTH{1'b0}}};
    else if (e <= 0)
      pack_sat = {sign, {(DATA_WIDTH-1){1'b0}}};
    else
      pack_sat = {sign, e[EXP_WIDTH-1:0], frac};
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    done_q, done_d, invalid_q, invalid_d;

  logic [DATA_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic                    sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic signed [EXS_W-1:0] exp_q, exp_d;
  logic [EXT_W-1:0]        ma_q, ma_d, mb_q, mb_d, norm_q, norm_d;
  logic                    spec_q, spec_d, spec_inv_q, spec_inv_d, zero_q, zero_d;
  logic [DATA_WIDTH-1:0]   spec_val_q, spec_val_d;
  logic [SUM_W-1:0]        sum_q, sum_d;

  logic [EXP_WIDTH-1:0]    ea, eb, e_big, e_sml, e_diff;
  logic                    a_nan, b_nan, a_inf, b_inf, swap;
  logic [DATA_WIDTH-2:0]   key_a, key_b;
  logic [DATA_WIDTH-1:0]   big, sml;
  logic [MAN_WIDTH:0]      man_big, man_sml;
  logic [2*EXT_W-1:0]      sh_ext;
  logic [EXT_W-1:0]        mb_al;
  logic [LZ_W-1:0]         lz;
  logic [MAN_WIDTH+1:0]    rnd;

  // ALIGN: order magnitudes (denormals count as zero) and right-shift the smaller with sticky.
  always_comb begin
    ea      = opa_q[DATA_WIDTH-2 -: EXP_WIDTH];
    eb      = opb_q[DATA_WIDTH-2 -: EXP_WIDTH];
    a_nan   = (ea == EXP_ALL1) && (opa_q[MAN_WIDTH-1:0] != '0);
    b_nan   = (eb == EXP_ALL1) && (opb_q[MAN_WIDTH-1:0] != '0);
    a_inf   = (ea == EXP_ALL1) && (opa_q[MAN_WIDTH-1:0] == '0);
    b_inf   = (eb == EXP_ALL1) && (opb_q[MAN_WIDTH-1:0] == '0);
    key_a   = (ea == '0) ? '0 : opa_q[DATA_WIDTH-2:0];
    key_b   = (eb == '0) ? '0 : opb_q[DATA_WIDTH-2:0];
    swap    = key_b > key_a;
    big     = swap ? opb_q : opa_q;
    sml     = swap ? opa_q : opb_q;
    e_big   = big[DATA_WIDTH-2 -: EXP_WIDTH];
    e_sml   = sml[DATA_WIDTH-2 -: EXP_WIDTH];
    man_big = (e_big != '0) ? {1'b1, big[MAN_WIDTH-1:0]} : '0;
    man_sml = (e_sml != '0) ? {1'b1, sml[MAN_WIDTH-1:0]} : '0;
    e_diff  = e_big - e_sml;
    sh_ext  = {man_sml, 3'b000, {EXT_W{1'b0}}} >> e_diff;
    if (e_diff >= EXP_WIDTH'(EXT_W))
      mb_al = {{(EXT_W-1){1'b0}}, |man_sml};
    else
      mb_al = sh_ext[2*EXT_W-1:EXT_W] | {{(EXT_W-1){1'b0}}, |sh_ext[EXT_W-1:0]};
  end

  always_comb begin
    opa_d      = opa_q;
    opb_d      = opb_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_inv_d = spec_inv_q;
    spec_val_d = spec_val_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    zero_d     = zero_q;
    lz         = lzc(sum_q[EXT_W-1:0]);
    case (state_q)
      S_IDLE: begin
        if (ena_sub_fp_clk) begin
          opa_d = data_in_1;
          opb_d = {~data_in_2[DATA_WIDTH-1], data_in_2[DATA_WIDTH-2:0]};
        end
      end
      S_ALIGN: begin
        sign_d     = big[DATA_WIDTH-1];
        eff_sub_d  = opa_q[DATA_WIDTH-1] ^ opb_q[DATA_WIDTH-1];
        exp_d      = $signed({2'b00, e_big});
        ma_d       = {man_big, 3'b000};
        mb_d       = mb_al;
        spec_d     = a_nan | b_nan | a_inf | b_inf;
        spec_inv_d = a_nan | b_nan | (a_inf & b_inf & (opa_q[DATA_WIDTH-1] != opb_q[DATA_WIDTH-1]));
        if (a_inf)
          spec_val_d = {opa_q[DATA_WIDTH-1], EXP_ALL1, {MAN_WIDTH{1'b0}}};
        else
          spec_val_d = {opb_q[DATA_WIDTH-1], EXP_ALL1, {MAN_WIDTH{1'b0}}};
        if (spec_inv_d) spec_val_d = QNAN;
      end
      // SUB: magnitudes are ordered, so the subtraction never goes negative.
      S_SUB: begin
        sum_d = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
      end
      // NORM: carry shifts right with sticky fold, otherwise single-cycle leading-zero shift.
      S_NORM: begin
        zero_d = (sum_q == '0);
        if (sum_q[SUM_W-1]) begin
          norm_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + $signed(EXS_W'(1));
        end else begin
          norm_d = sum_q[EXT_W-1:0] << lz;
          exp_d  = exp_q - $signed(EXS_W'(lz));
        end
      end
      default: ;
    endcase
  end

  // ROUND: result assembly feeds the output registers directly.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    invalid_d  = invalid_q;
    rnd        = round_mant(norm_q);
    case (state_q)
      S_IDLE:  if (ena_sub_fp_clk) state_d = S_ALIGN;
      S_ALIGN: state_d = S_SUB;
      S_SUB:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        invalid_d = spec_q & spec_inv_q;
        if (spec_q)      data_out_d = spec_val_q;
        else if (zero_q) data_out_d = '0;
        else             data_out_d = pack_sat(sign_q, exp_q, rnd);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_out_q <= '0;
      done_q     <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      invalid_q  <= invalid_d;
    end
  end

  always_ff @(posedge clk) begin
    opa_q      <= opa_d;
    opb_q      <= opb_d;
    sign_q     <= sign_d;
    eff_sub_q  <= eff_sub_d;
    exp_q      <= exp_d;
    ma_q       <= ma_d;
    mb_q       <= mb_d;
    spec_q     <= spec_d;
    spec_inv_q <= spec_inv_d;
    spec_val_q <= spec_val_d;
    sum_q      <= sum_d;
    norm_q     <= norm_d;
    zero_q     <= zero_d;
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign invalid  = invalid_q;
  assign busy     = (state_q != S_IDLE);

endmodule
